// File: rtl/duck_round_ctrl.sv
// duck_round_ctrl: round/score controller for the duck-hunt game.
// Tracks which birds are still alive, the ammo left, a saturating score and the
// number of missed rounds, and runs the game FSM. The trigger is sampled only on
// tick cycles, and a shot is a rising edge seen between two ticks.
// Optional feature: define DUCK_ROUND_BONUS_EN to credit unused ammo to the score
// when a round is cleared.

// Hit test for one bird. Deltas are taken larger-minus-smaller so they never wrap.
module duck_round_hit #(
  parameter int          X_W        = 8,
  parameter int          Y_W        = 7,
  parameter int unsigned HIT_RADIUS = 4
) (
  input  logic [X_W-1:0] x_player,
  input  logic [Y_W-1:0] y_player,
  input  logic [X_W-1:0] x_bird,
  input  logic [Y_W-1:0] y_bird,
  input  logic           alive,
  output logic           hit
);
  logic [X_W-1:0] dx;
  logic [Y_W-1:0] dy;

  assign dx  = (x_player >= x_bird) ? x_player - x_bird : x_bird - x_player;
  assign dy  = (y_player >= y_bird) ? y_player - y_bird : y_bird - y_player;
  assign hit = alive && (32'(dx) <= HIT_RADIUS) && (32'(dy) <= HIT_RADIUS);
endmodule

module duck_round_ctrl #(
  parameter  int          NUM_BIRDS       = 2,
  parameter  int          SHOTS_PER_ROUND = 3,
  parameter  int          SCORE_W         = 4,
  parameter  int          X_W             = 8,
  parameter  int          Y_W             = 7,
  parameter  int unsigned HIT_RADIUS      = 4,
  parameter  int          MAX_MISSED      = 3,
  localparam int          SW_W            = $clog2(SHOTS_PER_ROUND + 1)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     tick,
  input  logic                     start,
  input  logic                     trigger,
  input  logic [X_W-1:0]           x_player,
  input  logic [Y_W-1:0]           y_player,
  input  logic [NUM_BIRDS*X_W-1:0] x_birds,
  input  logic [NUM_BIRDS*Y_W-1:0] y_birds,
  output logic [NUM_BIRDS-1:0]     bird_alive,
  output logic [SW_W-1:0]          shots_left,
  output logic [SCORE_W-1:0]       score,
  output logic                     hit_pulse,
  output logic                     round_over,
  output logic                     game_over,
  output logic [2:0]               state
);
  localparam int MW = $clog2(MAX_MISSED + 1);
  localparam logic [MW-1:0] MISSED_LIM = MW'(MAX_MISSED);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARM       = 3'd1,
    S_WAIT_FIRE = 3'd2,
    S_RESOLVE   = 3'd3,
    S_ROUND_END = 3'd4,
    S_GAME_OVER = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_BIRDS-1:0] alive_q, alive_d;
  logic [NUM_BIRDS-1:0] mask_q, mask_d;
  logic [SW_W-1:0]      shots_q, shots_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [MW-1:0]        missed_q, missed_d;
  logic                 hit_pulse_q, hit_pulse_d;
  logic                 trig_prev;
  logic                 shot;
  logic [NUM_BIRDS-1:0] hit_now;
  logic [NUM_BIRDS-1:0] kill_oh;
  logic [NUM_BIRDS-1:0] alive_after;
  logic [SCORE_W-1:0]   score_inc, score_dec;
  logic [MW-1:0]        missed_inc;

  // Per-bird hit detectors against the live crosshair.
  for (genvar i = 0; i < NUM_BIRDS; i++) begin : g_lane
    duck_round_hit #(
      .X_W       (X_W),
      .Y_W       (Y_W),
      .HIT_RADIUS(HIT_RADIUS)
    ) u_hit (
      .x_player(x_player),
      .y_player(y_player),
      .x_bird  (x_birds[i*X_W +: X_W]),
      .y_bird  (y_birds[i*Y_W +: Y_W]),
      .alive   (alive_q[i]),
      .hit     (hit_now[i])
    );
  end

  assign shot = tick & trigger & ~trig_prev;

  // Lowest set bit of the captured mask is the one bird a shot may kill.
  assign kill_oh     = mask_q & (~mask_q + NUM_BIRDS'(1));
  assign alive_after = alive_q & ~kill_oh;

  assign score_inc  = (&score_q) ? score_q : score_q + 1'b1;
  assign score_dec  = (score_q == '0) ? score_q : score_q - 1'b1;
  assign missed_inc = missed_q + 1'b1;

`ifdef DUCK_ROUND_BONUS_EN
  localparam int BW = ((SCORE_W > SW_W) ? SCORE_W : SW_W) + 1;
  logic [BW-1:0]      bonus_sum;
  logic [SCORE_W-1:0] score_bonus;
  assign bonus_sum   = BW'(score_q) + BW'(shots_q);
  assign score_bonus = (bonus_sum > BW'({SCORE_W{1'b1}})) ? '1 : bonus_sum[SCORE_W-1:0];
`endif

  // Trigger history only advances on game-rate ticks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  trig_prev <= 1'b0;
    else if (tick) trig_prev <= trigger;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      alive_q     <= '0;
      mask_q      <= '0;
      shots_q     <= '0;
      score_q     <= '0;
      missed_q    <= '0;
      hit_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      alive_q     <= alive_d;
      mask_q      <= mask_d;
      shots_q     <= shots_d;
      score_q     <= score_d;
      missed_q    <= missed_d;
      hit_pulse_q <= hit_pulse_d;
    end
  end

  // Next-state and datapath updates for the game FSM.
  always_comb begin
    state_d     = state_q;
    alive_d     = alive_q;
    mask_d      = mask_q;
    shots_d     = shots_q;
    score_d     = score_q;
    missed_d    = missed_q;
    hit_pulse_d = 1'b0;
    case (state_q)
      S_IDLE, S_GAME_OVER: begin
        if (start) begin
          score_d  = '0;
          missed_d = '0;
          state_d  = S_ARM;
        end
      end
      S_ARM: begin
        shots_d = SW_W'(SHOTS_PER_ROUND);
        alive_d = '1;
        state_d = S_WAIT_FIRE;
      end
      S_WAIT_FIRE: begin
        if (shot && shots_q != '0) begin
          mask_d  = hit_now;
          shots_d = shots_q - 1'b1;
          state_d = S_RESOLVE;
        end
      end
      S_RESOLVE: begin
        // alive_after equals alive_q when nothing was hit.
        alive_d = alive_after;
        if (|mask_q) begin
          score_d     = score_inc;
          hit_pulse_d = 1'b1;
        end
        state_d = (alive_after == '0 || shots_q == '0) ? S_ROUND_END : S_WAIT_FIRE;
      end
      S_ROUND_END: begin
        if (|alive_q) begin
          score_d  = score_dec;
          missed_d = missed_inc;
          state_d  = (missed_inc >= MISSED_LIM) ? S_GAME_OVER : S_ARM;
        end else begin
`ifdef DUCK_ROUND_BONUS_EN
          if (shots_q != '0) score_d = score_bonus;
`endif
          state_d = S_ARM;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bird_alive = alive_q;
  assign shots_left = shots_q;
  assign score      = score_q;
  assign hit_pulse  = hit_pulse_q;
  assign round_over = (state_q == S_ROUND_END);
  assign game_over  = (state_q == S_GAME_OVER);
  assign state      = state_q;
endmodule

// File: tb/tb_duck_round_ctrl.sv
// Bench for duck_round_ctrl: directed game scenarios, a cycle-level reference
// model of the game rules, and hand-computed spot checks.
module tb_duck_round_ctrl;
  localparam int SPR  = 3;
  localparam int SMAX = 15;
  localparam int MAXM = 3;
  localparam int RAD  = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tick = 1'b0, start = 1'b0, trigger = 1'b0;
  logic [7:0]  x_player = '0;
  logic [6:0]  y_player = '0;
  logic [15:0] x_birds = {8'd42, 8'd40};
  logic [13:0] y_birds = {7'd31, 7'd30};
  logic [1:0]  bird_alive;
  logic [1:0]  shots_left;
  logic [3:0]  score;
  logic        hit_pulse, round_over, game_over;
  logic [2:0]  state;

  duck_round_ctrl dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .start(start), .trigger(trigger),
    .x_player(x_player), .y_player(y_player), .x_birds(x_birds), .y_birds(y_birds),
    .bird_alive(bird_alive), .shots_left(shots_left), .score(score),
    .hit_pulse(hit_pulse), .round_over(round_over), .game_over(game_over), .state(state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: game phase as an integer, counts as plain ints.
  int m_st, m_alive, m_shots, m_score, m_missed, m_mask, m_hp, m_tprev;

  function automatic bit near(input int i);
    int dx, dy;
    dx = int'(x_player) - int'(x_birds[i*8 +: 8]);
    dy = int'(y_player) - int'(y_birds[i*7 +: 7]);
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    return (dx <= RAD) && (dy <= RAD);
  endfunction

  task automatic model_step();
    bit sh;
    int k;
    sh = tick && trigger && (m_tprev == 0);
    if (tick) m_tprev = int'(trigger);
    m_hp = 0;
    case (m_st)
      0, 5: if (start) begin m_score = 0; m_missed = 0; m_st = 1; end
      1: begin m_shots = SPR; m_alive = 3; m_st = 2; end
      2: if (sh && m_shots > 0) begin
           m_mask = 0;
           for (int i = 0; i < 2; i++)
             if (m_alive[i] && near(i)) m_mask |= (1 << i);
           m_shots--;
           m_st = 3;
         end
      3: begin
           k = -1;
           for (int i = 1; i >= 0; i--) if (m_mask[i]) k = i;
           if (k >= 0) begin
             m_alive &= ~(1 << k);
             m_score = (m_score + 1 > SMAX) ? SMAX : m_score + 1;
             m_hp = 1;
           end
           m_st = (m_alive == 0 || m_shots == 0) ? 4 : 2;
         end
      4: begin
           if (m_alive != 0) begin
             m_score = (m_score > 0) ? m_score - 1 : 0;
             m_missed++;
             m_st = (m_missed >= MAXM) ? 5 : 1;
           end else begin
`ifdef DUCK_ROUND_BONUS_EN
             m_score = (m_score + m_shots > SMAX) ? SMAX : m_score + m_shots;
`endif
             m_st = 1;
           end
         end
      default: m_st = 0;
    endcase
  endtask

  // Model advances on the same edges as the design, including async reset.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_st = 0; m_alive = 0; m_shots = 0; m_score = 0;
      m_missed = 0; m_mask = 0; m_hp = 0; m_tprev = 0;
    end else model_step();
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk); #1;
      n_tests++;
      if (int'(state) != m_st || int'(bird_alive) != m_alive || int'(shots_left) != m_shots ||
          int'(score) != m_score || int'(hit_pulse) != m_hp ||
          int'(round_over) != int'(m_st == 4) || int'(game_over) != int'(m_st == 5)) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t dut st=%0d alive=%0d shots=%0d score=%0d hp=%0d ro=%0d go=%0d model st=%0d alive=%0d shots=%0d score=%0d hp=%0d",
                 $time, state, bird_alive, shots_left, score, hit_pulse, round_over, game_over,
                 m_st, m_alive, m_shots, m_score, m_hp);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Snapshots taken during a shot.
  int s1_shots, s1_hp, s2_hp, s2_score, s2_alive, s2_ro, s3_hp, s3_state;

  // One trigger press sampled on a tick, then release sampled on a later tick.
  task automatic fire(input int px, input int py);
    @(negedge clk); x_player = 8'(px); y_player = 7'(py); trigger = 1'b1; tick = 1'b1;
    @(negedge clk); #1; s1_shots = int'(shots_left); s1_hp = int'(hit_pulse);
    trigger = 1'b0; tick = 1'b0;
    @(negedge clk); #1; s2_hp = int'(hit_pulse); s2_score = int'(score);
    s2_alive = int'(bird_alive); s2_ro = int'(round_over); tick = 1'b1;
    @(negedge clk); #1; s3_hp = int'(hit_pulse); s3_state = int'(state); tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset_state", int'(state), 0);
    check("reset_score", int'(score), 0);
    check("reset_shots", int'(shots_left), 0);
    @(negedge clk); reset_n = 1'b1;

    // Start a game: ARM loads ammo and birds
    pulse_start();
    check("arm_shots", int'(shots_left), 3);
    check("arm_alive", int'(bird_alive), 3);
    check("arm_state", int'(state), 2);

    // Both birds in range: only the lowest index dies
    fire(41, 30);
    check("hit1_shots_same_edge", s1_shots, 2);
    check("hit1_hp_not_early", s1_hp, 0);
    check("hit1_hp", s2_hp, 1);
    check("hit1_alive", s2_alive, 2);
    check("hit1_score", s2_score, 1);
    check("hit1_hp_one_cycle", s3_hp, 0);

    // Second kill clears the round with one shot left
    fire(42, 31);
    check("clear_round_over", s2_ro, 1);
    check("clear_next_arm", s3_state, 1);
`ifdef DUCK_ROUND_BONUS_EN
    check("clear_score_bonus", int'(score), 3);
`else
    check("clear_score", int'(score), 2);
`endif

    // Drive score into saturation with cleared rounds
    repeat (7) begin
      fire(40, 30);
      fire(42, 31);
    end
    check("sat_score", int'(score), 15);
    fire(40, 30);
    check("sat_hit_hp", s2_hp, 1);
    check("sat_hit_score", s2_score, 15);

    // Trigger held across several ticks: a single shot
    @(negedge clk); x_player = 8'd0; y_player = 7'd0; trigger = 1'b1;
    repeat (4) begin
      tick = 1'b1; @(negedge clk);
      tick = 1'b0; @(negedge clk);
    end
    trigger = 1'b0; tick = 1'b1; @(negedge clk);
    tick = 1'b0; @(negedge clk); #1;
    check("held_one_shot", int'(shots_left), 1);

    // Reset mid-round
    @(negedge clk); reset_n = 1'b0; #1;
    check("midreset_state", int'(state), 0);
    check("midreset_score", int'(score), 0);
    check("midreset_alive", int'(bird_alive), 0);
    check("midreset_shots", int'(shots_left), 0);
    @(negedge clk); reset_n = 1'b1;
    pulse_start();
    check("restart_shots", int'(shots_left), 3);
    check("restart_alive", int'(bird_alive), 3);

    // start is ignored while playing
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    check("start_ignored", int'(state), 2);

    // Three misses: ammo drains, round fails, score stays at 0
    fire(0, 0);  check("miss_shots_a", s1_shots, 2);
    fire(0, 0);  check("miss_shots_b", s1_shots, 1);
    fire(0, 0);  check("miss_shots_c", s1_shots, 0);
    check("miss_round_over", s2_ro, 1);
    check("miss_next_arm", s3_state, 1);
    check("miss_score_floor", int'(score), 0);

    // Radius boundary: dx=4 hits, dx=5 misses; failed round takes the point back
    fire(44, 30);
    check("edge_r4_hit", s2_hp, 1);
    check("edge_r4_score", s2_score, 1);
    fire(47, 31);
    check("edge_r5_miss", s2_hp, 0);
    fire(0, 0);
    check("penalty_score", int'(score), 0);

    // Third failed round ends the game
    fire(0, 0); fire(0, 0); fire(0, 0);
    check("gameover_state_snap", s3_state, 5);
    check("gameover_level", int'(game_over), 1);
    check("gameover_state", int'(state), 5);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    check("newgame_arm", int'(state), 1);
    check("newgame_score", int'(score), 0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
